// File: rtl/trace_capture_unit.sv
// trace_capture_unit: retire-trace recorder for the pipelined datapath.
// Write-back events are stamped with a free-running cycle count and stored in a
// circular buffer. Three capture modes are supported: wrap, stop-on-full, and
// PC trigger with a post-trigger count. Entries drain oldest-first through a
// valid/ready read port.
module trace_capture_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic                     wb_regwrite,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [1:0]               mode,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic [$clog2(DEPTH):0]   post_count,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_data,
  output logic [4:0]               rd_rd,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CYC_W-1:0]         cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_remain;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic              r_overflow;
  logic [CYC_W-1:0]  r_cycle;

  logic [XLEN-1:0]   r_mem_pc   [DEPTH];
  logic [XLEN-1:0]   r_mem_data [DEPTH];
  logic [4:0]        r_mem_rd   [DEPTH];
  logic [CYC_W-1:0]  r_mem_cyc  [DEPTH];

  logic w_capturing;
  logic w_full;
  logic w_mode_stop_full;
  logic w_mode_trig;
  logic w_we;
  logic w_trig_hit;
  logic w_fills_last;

  assign w_capturing      = (r_state == S_CAPTURE) || (r_state == S_POST);
  assign w_full           = (r_count == CW'(DEPTH));
  assign w_mode_stop_full = (mode == 2'd1);
  assign w_mode_trig      = (mode == 2'd2);
  // In stop-on-full mode a full buffer drops further events instead of wrapping.
  assign w_we             = !reset && !arm && w_capturing && wb_valid &&
                            !(w_mode_stop_full && w_full);
  assign w_trig_hit       = w_we && (r_state == S_CAPTURE) && w_mode_trig &&
                            (wb_pc == trig_pc);
  assign w_fills_last     = w_we && w_mode_stop_full && (r_count == CW'(DEPTH - 1));

  // Trace buffer storage; contents need no reset because pointers bound validity.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem_pc[r_wptr]   <= wb_pc;
      r_mem_data[r_wptr] <= wb_data;
      r_mem_rd[r_wptr]   <= wb_regwrite ? wb_rd : 5'd0;
      r_mem_cyc[r_wptr]  <= r_cycle;
    end
  end

  // Capture/readout control FSM with pointers, fill count and cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= {CW{1'b0}};
      r_remain   <= {CW{1'b0}};
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_overflow <= 1'b0;
      r_cycle    <= {CYC_W{1'b0}};
    end else begin
      r_cycle <= r_cycle + CYC_W'(1);
      if (arm) begin
        r_state    <= S_CAPTURE;
        r_count    <= {CW{1'b0}};
        r_wptr     <= {AW{1'b0}};
        r_rptr     <= {AW{1'b0}};
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          S_CAPTURE, S_POST: begin
            if (w_we) begin
              r_wptr <= r_wptr + AW'(1);
              if (w_full) begin
                // Wrap: the oldest entry is overwritten.
                r_rptr     <= r_rptr + AW'(1);
                r_overflow <= 1'b1;
              end else begin
                r_count <= r_count + CW'(1);
              end
            end
            if (stop || w_fills_last) begin
              r_state <= S_DONE;
            end else if (w_trig_hit) begin
              r_remain <= post_count;
              r_state  <= (post_count == {CW{1'b0}}) ? S_DONE : S_POST;
            end else if (w_we && (r_state == S_POST)) begin
              r_remain <= r_remain - CW'(1);
              if (r_remain == CW'(1)) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_POST;
              end
            end else begin
              r_state <= r_state;
            end
          end
          S_DONE: begin
            if (r_count == {CW{1'b0}}) begin
              r_state <= S_IDLE;
            end else if (rd_ready) begin
              r_rptr  <= r_rptr + AW'(1);
              r_count <= r_count - CW'(1);
              if (r_count == CW'(1)) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_state <= S_DONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_valid    = (r_state == S_DONE) && (r_count != {CW{1'b0}});
  assign rd_pc       = r_mem_pc[r_rptr];
  assign rd_data     = r_mem_data[r_rptr];
  assign rd_rd       = r_mem_rd[r_rptr];
  assign rd_cycle    = r_mem_cyc[r_rptr];
  assign state       = r_state;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Self-checking bench for trace_capture_unit (DEPTH=8): directed scenarios
// followed by randomized traffic, compared each cycle against a queue model.
module tb_trace_capture_unit;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [63:0] wb_pc = 64'd0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_data = 64'd0;
  logic [1:0]  mode = 2'd0;
  logic [63:0] trig_pc = 64'd0;
  logic [3:0]  post_count = 4'd0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [63:0] rd_pc;
  logic [63:0] rd_data;
  logic [4:0]  rd_rd;
  logic [31:0] rd_cycle;
  logic [1:0]  state;
  logic [3:0]  count;
  logic        overflow;
  logic [31:0] cycle_count;

  trace_capture_unit #(.XLEN(64), .DEPTH(DEPTH), .CYC_W(32)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .mode(mode),
    .trig_pc(trig_pc), .post_count(post_count), .arm(arm), .stop(stop),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_data(rd_data),
    .rd_rd(rd_rd), .rd_cycle(rd_cycle), .state(state), .count(count),
    .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cyc;
  } ent_t;

  ent_t        m_q[$];
  int          m_state = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_cyc = 32'd0;
  int          m_remain = 0;

  int n_pass = 0;
  int n_total = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance the behavioural model by one clock using the inputs now applied.
  task automatic model_step();
    ent_t e;
    int   ns;
    bit   wrote;
    if (reset) begin
      m_state = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
      return;
    end
    e.pc = wb_pc;
    e.rd = wb_regwrite ? wb_rd : 5'd0;
    e.data = wb_data;
    e.cyc = m_cyc;
    m_cyc = m_cyc + 32'd1;
    if (arm) begin
      m_state = 1;
      m_q.delete();
      m_ovf = 1'b0;
    end else if (m_state == 1 || m_state == 2) begin
      ns = m_state;
      wrote = 1'b0;
      if (wb_valid && !(mode == 2'd1 && m_q.size() == DEPTH)) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_q.push_back(e);
        wrote = 1'b1;
      end
      if (wrote && mode == 2'd1 && m_q.size() == DEPTH) begin
        ns = 3;
      end else if (wrote && m_state == 1 && mode == 2'd2 && wb_pc == trig_pc) begin
        m_remain = int'(post_count);
        ns = (post_count == 4'd0) ? 3 : 2;
      end else if (wrote && m_state == 2) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) ns = 3;
      end
      if (stop) ns = 3;
      m_state = ns;
    end else if (m_state == 3) begin
      if (m_q.size() == 0) begin
        m_state = 0;
      end else if (rd_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_state = 0;
      end
    end
  endtask

  // Compare every observable output against the model.
  task automatic check();
    bit exp_valid;
    exp_valid = (m_state == 3) && (m_q.size() != 0);
    cmp("state", state, m_state);
    cmp("count", count, m_q.size());
    cmp("overflow", overflow, m_ovf);
    cmp("cycle_count", cycle_count, m_cyc);
    cmp("rd_valid", rd_valid, exp_valid);
    if (exp_valid) begin
      cmp("rd_pc", rd_pc, m_q[0].pc);
      cmp("rd_data", rd_data, m_q[0].data);
      cmp("rd_rd", rd_rd, m_q[0].rd);
      cmp("rd_cycle", rd_cycle, m_q[0].cyc);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check();
  endtask

  task automatic ev(input logic [63:0] pc);
    wb_valid = 1'b1;
    wb_pc = pc;
    wb_regwrite = 1'($urandom_range(0, 1));
    wb_rd = 5'($urandom);
    wb_data = {$urandom, $urandom};
    step();
    wb_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    int          pat[5];
    logic [63:0] held;
    logic [31:0] prev;
    pat = '{1, 0, 0, 1, 1};

    // Reset and idle behaviour
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp("rst_cycle", cycle_count, 64'd0);
    cmp("rst_state", state, 64'd0);
    cmp("rst_count", count, 64'd0);
    cmp("rst_valid", rd_valid, 64'd0);
    cmp("rst_ovf", overflow, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      cmp("idle_cycle", cycle_count, 64'(i));
    end
    ev(64'h40);
    ev(64'h44);
    cmp("idle_count", count, 64'd0);

    // Stop-on-full
    mode = 2'd1;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      ev(64'(4 * i));
      if (i == 7) begin
        cmp("sof_state", state, 64'd3);
        cmp("sof_count", count, 64'd8);
        cmp("sof_ovf", overflow, 64'd0);
      end
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmp("sof_rd_pc", rd_pc, 64'(4 * i));
      step();
    end
    rd_ready = 1'b0;
    cmp("sof_idle", state, 64'd0);

    // Wrap then stop
    mode = 2'd0;
    do_arm();
    for (int i = 0; i < 11; i++) ev(64'(4 * i));
    stop = 1'b1;
    step();
    stop = 1'b0;
    cmp("wrap_ovf", overflow, 64'd1);
    cmp("wrap_count", count, 64'd8);
    rd_ready = 1'b1;
    prev = 32'd0;
    for (int i = 0; i < 8; i++) begin
      cmp("wrap_rd_pc", rd_pc, 64'(12 + 4 * i));
      if (i > 0) cmp("wrap_cyc_incr", 64'(rd_cycle > prev), 64'd1);
      prev = rd_cycle;
      step();
    end
    rd_ready = 1'b0;

    // Trigger with post count, then backpressured drain
    mode = 2'd2;
    trig_pc = 64'h20;
    post_count = 4'd2;
    do_arm();
    for (int i = 0; i < 11; i++) begin
      ev(64'(4 * i));
      if (i == 8) cmp("trig_post", state, 64'd2);
      if (i == 10) cmp("trig_done", state, 64'd3);
    end
    cmp("trig_count", count, 64'd8);
    cmp("trig_first", rd_pc, 64'h0C);
    for (int k = 0; k < 5; k++) begin
      held = rd_pc;
      rd_ready = pat[k][0];
      step();
      if (pat[k] == 0) cmp("bp_hold", rd_pc, held);
    end
    cmp("bp_count", count, 64'd5);
    cmp("bp_pc", rd_pc, 64'h18);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_ready = 1'b0;
    cmp("bp_idle", state, 64'd0);

    // arm beats stop; reset during POST
    mode = 2'd0;
    do_arm();
    for (int i = 0; i < 5; i++) ev(64'(4 * i));
    cmp("as_count5", count, 64'd5);
    arm = 1'b1;
    stop = 1'b1;
    step();
    arm = 1'b0;
    stop = 1'b0;
    cmp("as_state", state, 64'd1);
    cmp("as_count", count, 64'd0);
    mode = 2'd2;
    trig_pc = 64'h100;
    post_count = 4'd3;
    ev(64'h100);
    cmp("post_state", state, 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp("rp_state", state, 64'd0);
    cmp("rp_count", count, 64'd0);
    cmp("rp_ovf", overflow, 64'd0);
    cmp("rp_cycle", cycle_count, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      arm = ($urandom_range(0, 59) == 0);
      if (arm) begin
        mode = 2'($urandom_range(0, 3));
        trig_pc = 64'(4 * $urandom_range(0, 15));
        post_count = 4'($urandom_range(0, 8));
      end
      stop = ($urandom_range(0, 39) == 0);
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_pc = 64'(4 * $urandom_range(0, 15));
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom);
      wb_data = {$urandom, $urandom};
      rd_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Parametrised retire-trace recorder for the 5-stage pipelined datapath. It samples each write-back (retire) event into a circular on-chip buffer of `DEPTH` entries, stamps each entry with a free-running cycle count, and supports three capture modes: continuous wrap, stop-on-full, and PC-triggered with post-trigger count. Captured entries drain oldest-first through a valid/ready read port. It sits beside the datapath, fed from the MEM/WB pipeline registers, and lets benches and on-target debug inspect retirement history without per-cycle `$display` probing.

## Interface
- `XLEN`, 64, width of PC and write-back data
- `DEPTH`, 16, buffer entries; power of 2, ≥2
- `CYC_W`, 32, cycle-stamp width
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `wb_valid`  in  1  an instruction retires this cycle
- `wb_pc`  in  XLEN  PC of the retiring instruction
- `wb_regwrite`  in  1  retiring instruction writes a register
- `wb_rd`  in  5  destination register
- `wb_data`  in  XLEN  write-back data
- `mode`  in  2  0 = wrap, 1 = stop-on-full, 2 = trigger, 3 = treated as 0
- `trig_pc`  in  XLEN  trigger PC (mode 2)
- `post_count`  in  $clog2(DEPTH)+1  entries captured after the trigger entry
- `arm`  in  1  pulse: clear the buffer and start capture
- `stop`  in  1  pulse: end capture
- `rd_ready`  in  1  consumer accepts the read entry
- `rd_valid`  out  1  read entry available
- `rd_pc`, `rd_data`  out  XLEN  entry fields
- `rd_rd`  out  5  entry destination register; 0 if `wb_regwrite` was 0
- `rd_cycle`  out  CYC_W  entry cycle stamp
- `state`  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
- `count`  out  $clog2(DEPTH)+1  valid entries held
- `overflow`  out  1  an entry was overwritten since the last arm
- `cycle_count`  out  CYC_W  free-running cycle counter

## Operation
- `reset` forces IDLE and clears `count`, the read and write pointers, `overflow`, and `cycle_count`. `rd_valid` is 0.
- `cycle_count` increments every cycle after reset and wraps modulo 2^CYC_W.
- `arm` in any state moves to CAPTURE and clears `count`, pointers, and `overflow`. A `wb_valid` in the arm cycle is not captured. When `arm` and `stop` are asserted together, `arm` wins.
- CAPTURE/POST: each `wb_valid` writes {`wb_pc`, rd, `wb_data`, `cycle_count`} at the write pointer, which then advances.
  - Mode 0/3: when full, the write overwrites the oldest entry. The read pointer advances, `count` stays `DEPTH`, and `overflow` is set.
  - Mode 1: the write that makes `count` equal `DEPTH` moves the block to DONE. Later events are dropped and `overflow` stays 0.
  - Mode 2: wraps as in mode 0. A `wb_valid` with `wb_pc == trig_pc` in CAPTURE is written, then a remaining counter is loaded with `post_count`. The block goes to POST, or to DONE if `post_count` = 0. In POST, each write decrements the remaining counter, and reaching 0 moves the block to DONE. Trigger matches in POST are ignored.
- `stop` in CAPTURE or POST moves the block to DONE. A `wb_valid` in the same cycle is still captured. `stop` in IDLE or DONE has no effect.
- DONE: `rd_valid` = (`count` != 0). The `rd_*` outputs show the oldest entry. A cycle with `rd_valid && rd_ready` pops that entry: the read pointer advances and `count` decrements. When `count` reaches 0, the block goes to IDLE. No pops occur outside DONE.
- IDLE ignores `wb_valid`.

## Timing
- A write becomes visible in `count` and the buffer one cycle after the sampled `wb_valid`.
- State transitions take effect on the clock edge after the causing event.
- `rd_*` are driven combinationally from the buffer at the read pointer. They hold stable while `rd_valid && !rd_ready`. Back-to-back pops are allowed, one entry per cycle.
- Entering DONE with `count` > 0 asserts `rd_valid` in the next cycle.
- Pointers wrap modulo `DEPTH`. `count` saturates at `DEPTH`.
- `reset` asserted mid-capture or mid-readout takes priority over every other input. The state in the following cycle is the full reset state.

## Test plan
- Reset, then 5 idle cycles: `state`=0, `count`=0, `rd_valid`=0, `overflow`=0, and `cycle_count` goes 0,1,2,3,4. `wb_valid` pulses in IDLE leave `count`=0.
- `DEPTH`=8, mode 1, arm, then 10 events at PCs 0x0,0x4,…,0x24: DONE after the 8th event, `count`=8, `overflow`=0. Drain with `rd_ready` held at 1: PCs 0x0…0x1C over 8 consecutive cycles, then `state`=IDLE.
- Mode 0, arm, 11 events at PCs 0x0…0x28, then stop: `overflow`=1, `count`=8, drain yields PCs 0x0C…0x28 with strictly increasing `rd_cycle`.
- Mode 2, `trig_pc`=0x20, `post_count`=2, events at PCs 0x0,0x4,…: POST after event 0x20, DONE after 0x28. Readout gives 0x0C…0x28, 8 entries.
- Backpressure: drain with `rd_ready` pattern 1,0,0,1,1. `rd_pc` stays unchanged across the 0-cycles, and exactly 3 entries pop.
- `arm`+`stop` together in CAPTURE with `count`=5: the next state is CAPTURE with `count`=0. A `reset` asserted in POST gives IDLE, `count`=0, `overflow`=0, `cycle_count`=0 on the next cycle.
